pc_sequencer: RTL and testbench

- Fetch/decode/execute controller for the program counter of the gpp_calc processor.
- Drives the PC's control inputs (write, branch, stack-pop, factorial-hold) from decoded opcode flags.
- Handshakes instruction fetch with memory and sequences multi-cycle FACT operations.
- Holds an internal return-address stack for CALL/RET.

---
 rtl/pc_sequencer_if.sv | 50 +++++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer handshake bundle: fetch, decoded op flags, FACT unit and PC control.
// PC_SEQ_SINGLE_STEP_EN adds the step input.
interface pc_sequencer_if #(
   parameter int AW = 16
);
`ifdef PC_SEQ_SINGLE_STEP_EN
   logic          step;
`endif
   logic          start;
   logic [AW-1:0] pc_cur;
   logic          mem_req;
   logic          mem_ack;
   logic          ir_load;
   logic          op_branch;
   logic          op_call;
   logic          op_ret;
   logic          op_fact;
   logic          op_halt;
   logic          cond;
   logic          fact_start;
   logic          fact_done;
   logic          pc_w;
   logic          pc_bra;
   logic          pc_stack_pop;
   logic          pc_fact;
   logic [AW-1:0] ret_addr;
   logic          busy;
   logic          halted;
   logic          stack_err;

   modport master (
`ifdef PC_SEQ_SINGLE_STEP_EN
      input  step,
`endif
      input  start, pc_cur, mem_ack, op_branch, op_call, op_ret, op_fact, op_halt,
             cond, fact_done,
      output mem_req, ir_load, fact_start, pc_w, pc_bra, pc_stack_pop, pc_fact,
             ret_addr, busy, halted, stack_err
   );

   modport slave (
`ifdef PC_SEQ_SINGLE_STEP_EN
      output step,
`endif
      output start, pc_cur, mem_ack, op_branch, op_call, op_ret, op_fact, op_halt,
             cond, fact_done,
      input  mem_req, ir_load, fact_start, pc_w, pc_bra, pc_stack_pop, pc_fact,
             ret_addr, busy, halted, stack_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: FETCH (waits on mem_ack) -> DECODE -> [FACT_WAIT] -> UPDATE, plus CALL/RET stack.
// Plain instruction takes 3 cycles. PC_SEQ_SINGLE_STEP_EN inserts a step-gated PAUSE after UPDATE.
module pc_sequencer #(
   parameter int AW    = 16,
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.master bus
);
   localparam int SPW = $clog2(DEPTH);
   localparam logic [SPW:0] SP_FULL = DEPTH[SPW:0];

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_FACT_WAIT, S_UPDATE, S_HALT, S_ERR
`ifdef PC_SEQ_SINGLE_STEP_EN
      , S_PAUSE
`endif
   } state_t;

   typedef enum logic [1:0] {U_INC, U_BRA, U_RET} upd_t;

   state_t        state, state_nxt;
   upd_t          upd_kind, upd_nxt;
   logic          fact_first;
   logic [SPW:0]  sp;
   logic [SPW-1:0] top_idx;
   logic          push, pop;
   logic [AW-1:0] ret_addr_q;
   logic [AW-1:0] stk [DEPTH];

   assign top_idx = sp[SPW-1:0] - 1'b1;

   always_comb begin
      state_nxt = state;
      upd_nxt   = upd_kind;
      push      = 1'b0;
      pop       = 1'b0;
      case (state)
         S_IDLE:   if (bus.start) state_nxt = S_FETCH;
         S_FETCH:  if (bus.mem_ack) state_nxt = S_DECODE;
         S_DECODE: begin
            // Flag priority: halt > ret > call > branch > fact > plain.
            if (bus.op_halt) begin
               state_nxt = S_HALT;
            end else if (bus.op_ret) begin
               if (sp == '0) begin
                  state_nxt = S_ERR;
               end else begin
                  pop       = 1'b1;
                  upd_nxt   = U_RET;
                  state_nxt = S_UPDATE;
               end
            end else if (bus.op_call) begin
               if (sp == SP_FULL) begin
                  state_nxt = S_ERR;
               end else begin
                  push      = 1'b1;
                  upd_nxt   = U_BRA;
                  state_nxt = S_UPDATE;
               end
            end else if (bus.op_branch) begin
               upd_nxt   = bus.cond ? U_BRA : U_INC;
               state_nxt = S_UPDATE;
            end else if (bus.op_fact) begin
               state_nxt = S_FACT_WAIT;
            end else begin
               upd_nxt   = U_INC;
               state_nxt = S_UPDATE;
            end
         end
         S_FACT_WAIT: begin
            if (bus.fact_done) begin
               upd_nxt   = U_INC;
               state_nxt = S_UPDATE;
            end
         end
`ifdef PC_SEQ_SINGLE_STEP_EN
         S_UPDATE: state_nxt = S_PAUSE;
         S_PAUSE:  if (bus.step) state_nxt = S_FETCH;
`else
         S_UPDATE: state_nxt = S_FETCH;
`endif
         S_HALT:   state_nxt = S_HALT;
         S_ERR:    state_nxt = S_ERR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         upd_kind   <= U_INC;
         fact_first <= 1'b0;
         sp         <= '0;
         ret_addr_q <= '0;
      end else begin
         state      <= state_nxt;
         upd_kind   <= upd_nxt;
         fact_first <= (state == S_DECODE) && (state_nxt == S_FACT_WAIT);
         if (push) begin
            sp <= sp + 1'b1;
         end else if (pop) begin
            sp         <= sp - 1'b1;
            ret_addr_q <= stk[top_idx];
         end
      end
   end

   // Stack contents survive reset; only sp is cleared.
   always_ff @(posedge clk) begin
      if (push && !rst) stk[sp[SPW-1:0]] <= bus.pc_cur + 1'b1;
   end

   assign bus.mem_req      = (state == S_FETCH);
   assign bus.ir_load      = (state == S_FETCH) && bus.mem_ack;
   assign bus.fact_start   = (state == S_FACT_WAIT) && fact_first;
   assign bus.pc_fact      = (state == S_FACT_WAIT);
   assign bus.pc_w         = (state == S_UPDATE);
   assign bus.pc_bra       = (state == S_UPDATE) && (upd_kind == U_BRA);
   assign bus.pc_stack_pop = (state == S_UPDATE) && (upd_kind == U_RET);
   assign bus.ret_addr     = ret_addr_q;
   assign bus.busy         = (state == S_FETCH) || (state == S_DECODE) ||
                             (state == S_FACT_WAIT) || (state == S_UPDATE);
   assign bus.halted       = (state == S_HALT);
   assign bus.stack_err    = (state == S_ERR);
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: an instruction-level model (queue stack, per-op cycle script)
// predicts the control outputs each cycle.
module tb_pc_sequencer;
   localparam int AW    = 16;
   localparam int DEPTH = 8;

   // {mem_req, ir_load, fact_start, pc_w, pc_bra, pc_stack_pop, pc_fact, busy, halted, stack_err}
   localparam logic [9:0] O_IDLE   = 10'b00_0000_0000;
   localparam logic [9:0] O_FETCHW = 10'b10_0000_0100;
   localparam logic [9:0] O_FETCHA = 10'b11_0000_0100;
   localparam logic [9:0] O_DEC    = 10'b00_0000_0100;
   localparam logic [9:0] O_FACT1  = 10'b00_1000_1100;
   localparam logic [9:0] O_FACTN  = 10'b00_0000_1100;
   localparam logic [9:0] O_INC    = 10'b00_0100_0100;
   localparam logic [9:0] O_BRA    = 10'b00_0110_0100;
   localparam logic [9:0] O_RET    = 10'b00_0101_0100;
   localparam logic [9:0] O_HALT   = 10'b00_0000_0010;
   localparam logic [9:0] O_ERR    = 10'b00_0000_0001;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [AW-1:0] stk_q [$];

   pc_sequencer_if #(.AW(AW)) bus ();
   pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {bus.mem_req, bus.ir_load, bus.fact_start, bus.pc_w, bus.pc_bra,
              bus.pc_stack_pop, bus.pc_fact, bus.busy, bus.halted, bus.stack_err};
   endfunction

   // Inputs that the current state must ignore are kept random.
   task automatic junk();
      bus.start     = 1'($urandom);
      bus.pc_cur    = AW'($urandom);
      bus.mem_ack   = 1'($urandom);
      bus.op_branch = 1'($urandom);
      bus.op_call   = 1'($urandom);
      bus.op_ret    = 1'($urandom);
      bus.op_fact   = 1'($urandom);
      bus.op_halt   = 1'($urandom);
      bus.cond      = 1'($urandom);
      bus.fact_done = 1'($urandom);
`ifdef PC_SEQ_SINGLE_STEP_EN
      bus.step      = 1'($urandom);
`endif
   endtask

   task automatic cyc(input string tag, input logic [9:0] exp, input int ret_exp);
      @(negedge clk);
      check_val(tag, {22'd0, outs()}, {22'd0, exp});
      if (ret_exp >= 0) check_val({tag, "_ret_addr"}, {16'd0, bus.ret_addr}, ret_exp);
      @(posedge clk);
      #1;
      junk();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      junk();
      bus.start = 1'b0;
      stk_q.delete();
      cyc("reset_idle", O_IDLE, 0);
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cyc("idle_start", O_IDLE, -1);
   endtask

   // ops = {halt, ret, call, branch, fact}
   task automatic run_instr(input int ack_dly, input logic [4:0] ops, input logic c,
                            input logic [AW-1:0] pc, input int fdly, input bit rst_mid,
                            output bit ended);
      logic [AW-1:0] ra;
      logic [AW-1:0] link;
      ended = 1'b0;
      for (int i = 0; i < ack_dly; i++) begin
         bus.mem_ack = 1'b0;
         cyc("fetch_wait", O_FETCHW, -1);
      end
      bus.mem_ack = 1'b1;
      cyc("fetch_ack", O_FETCHA, -1);
      {bus.op_halt, bus.op_ret, bus.op_call, bus.op_branch, bus.op_fact} = ops;
      bus.cond   = c;
      bus.pc_cur = pc;
      cyc("decode", O_DEC, -1);

      if (ops[4]) begin
         cyc("halt", O_HALT, -1);
         cyc("halt_hold", O_HALT, -1);
         ended = 1'b1;
      end else if (ops[3]) begin
         if (stk_q.size() == 0) begin
            cyc("ret_underflow", O_ERR, -1);
            cyc("err_hold", O_ERR, -1);
            ended = 1'b1;
         end else begin
            ra = stk_q.pop_back();
            cyc("upd_ret", O_RET, int'(ra));
         end
      end else if (ops[2]) begin
         if (stk_q.size() == DEPTH) begin
            cyc("call_overflow", O_ERR, -1);
            cyc("err_hold", O_ERR, -1);
            ended = 1'b1;
         end else begin
            link = pc + 1'b1;
            stk_q.push_back(link);
            cyc("upd_call", O_BRA, -1);
         end
      end else if (ops[1]) begin
         cyc(c ? "upd_br_taken" : "upd_br_not", c ? O_BRA : O_INC, -1);
      end else if (ops[0]) begin
         for (int k = 1; k <= fdly; k++) begin
            bus.fact_done = (k == fdly);
            if (rst_mid && k == 2) begin
               bus.fact_done = 1'b0;
               rst = 1'b1;
               cyc("fact_wait_rst", O_FACTN, -1);
               rst = 1'b0;
               bus.start = 1'b0;
               stk_q.delete();
               cyc("fact_rst_idle", O_IDLE, 0);
               ended = 1'b1;
               return;
            end
            cyc(k == 1 ? "fact_first" : "fact_wait", k == 1 ? O_FACT1 : O_FACTN, -1);
         end
         cyc("upd_fact_inc", O_INC, -1);
      end else begin
         cyc("upd_plain", O_INC, -1);
      end
`ifdef PC_SEQ_SINGLE_STEP_EN
      if (!ended) begin
         bus.step = 1'b1;
         cyc("pause", O_IDLE, -1);
      end
`endif
   endtask

   initial begin
      bit ended;
      logic [4:0] ops;
      int fdly;
      bit rmid;
      logic [AW-1:0] pc;

      junk();
      rst = 1'b1;
      do_reset();
      do_start();

      // Plain ops, same-cycle ack
      for (int i = 0; i < 3; i++) run_instr(0, 5'b00000, 1'b0, 16'h0010, 1, 1'b0, ended);
      // Branch taken then not taken
      run_instr(0, 5'b00010, 1'b1, 16'h0020, 1, 1'b0, ended);
      run_instr(1, 5'b00010, 1'b0, 16'h0021, 1, 1'b0, ended);
      // Call/ret return address, including wrap at the top of the address space
      run_instr(0, 5'b00100, 1'b0, 16'h86AB, 1, 1'b0, ended);
      run_instr(2, 5'b00000, 1'b0, 16'h1234, 1, 1'b0, ended);
      run_instr(0, 5'b01000, 1'b0, 16'h5555, 1, 1'b0, ended);
      run_instr(0, 5'b00100, 1'b0, 16'hFFFF, 1, 1'b0, ended);
      run_instr(0, 5'b01000, 1'b0, 16'h0003, 1, 1'b0, ended);

      // Fill the stack, then one call too many
      do_reset();
      do_start();
      for (int i = 0; i <= DEPTH; i++)
         run_instr(0, 5'b00100, 1'b0, AW'(16'h0100 + i), 1, 1'b0, ended);
      // Empty-stack return
      do_reset();
      do_start();
      run_instr(0, 5'b01000, 1'b0, 16'h0000, 1, 1'b0, ended);

      // FACT: 5-cycle wait, same-cycle done, reset mid-wait
      do_reset();
      do_start();
      run_instr(0, 5'b00001, 1'b0, 16'h0040, 5, 1'b0, ended);
      run_instr(0, 5'b00001, 1'b0, 16'h0041, 1, 1'b0, ended);
      run_instr(0, 5'b00001, 1'b0, 16'h0042, 4, 1'b1, ended);

      // Delayed ack, then halt beating call
      do_start();
      run_instr(4, 5'b00000, 1'b0, 16'h0050, 1, 1'b0, ended);
      run_instr(0, 5'b10100, 1'b0, 16'h0051, 1, 1'b0, ended);

      do_reset();
      do_start();
      for (int n = 0; n < 400; n++) begin
         ops[4] = ($urandom_range(0, 99) < 3);
         ops[3] = ($urandom_range(0, 99) < 25);
         ops[2] = ($urandom_range(0, 99) < 35);
         ops[1] = ($urandom_range(0, 99) < 40);
         ops[0] = ($urandom_range(0, 99) < 25);
         rmid   = ($urandom_range(0, 49) == 0);
         fdly   = rmid ? int'($urandom_range(3, 6)) : int'($urandom_range(1, 6));
         pc     = ($urandom_range(0, 9) == 0) ? 16'hFFFF : AW'($urandom);
         run_instr(int'($urandom_range(0, 3)), ops, 1'($urandom), pc, fdly, rmid, ended);
         if (ended) begin
            do_reset();
            do_start();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
